// File: rtl/systolic_operand_feeder_pkg.sv
// Shared types and defaults for the systolic operand feeder and array.
// Holds the feeder state encoding and element lane offset helper.
package systolic_operand_feeder_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_N_SIZE    = 3;

    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN
    } feeder_state_e;

    function automatic int lane_off(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_operand_row_store.sv
// N x N element register file: row-write port, one combinational read port
// returning either column rd_idx (COL_READ=1) or row rd_idx (COL_READ=0).
module systolic_operand_feeder_operand_row_store
    import systolic_operand_feeder_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int N_SIZE    = DEF_N_SIZE,
    parameter int ROW_W     = $clog2(N_SIZE),
    parameter bit COL_READ  = 1'b1
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ROW_W-1:0]            wr_row,
    input  logic [N_SIZE*DATAWIDTH-1:0] wr_data,
    input  logic [ROW_W-1:0]            rd_idx,
    output logic [N_SIZE*DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem [N_SIZE][N_SIZE];

    // Operand storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < N_SIZE; c++) begin
                mem[wr_row][c] <= wr_data[lane_off(c, DATAWIDTH) +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int l = 0; l < N_SIZE; l++) begin
            if (COL_READ) begin
                rd_data[lane_off(l, DATAWIDTH) +: DATAWIDTH] = mem[l][rd_idx];
            end else begin
                rd_data[lane_off(l, DATAWIDTH) +: DATAWIDTH] = mem[rd_idx][l];
            end
        end
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers A/B operand rows, then clears and streams N lane-parallel beats.
// Define FEEDER_ERR_EN to add the sticky err_row output.
module systolic_operand_feeder
    import systolic_operand_feeder_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int N_SIZE       = DEF_N_SIZE,
    parameter int DRAIN_CYCLES = 2 * N_SIZE,
    localparam int ROW_W       = $clog2(N_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic                        wr_sel,
    input  logic [ROW_W-1:0]            wr_row,
    input  logic [N_SIZE*DATAWIDTH-1:0] wr_data,
    output logic                        acc_clear,
    output logic                        valid_out,
    output logic [N_SIZE*DATAWIDTH-1:0] matrix_a_out,
    output logic [N_SIZE*DATAWIDTH-1:0] matrix_b_out,
    output logic                        busy,
    output logic                        done
`ifdef FEEDER_ERR_EN
    ,
    output logic                        err_row
`endif
);

    localparam int W       = N_SIZE * DATAWIDTH;
    localparam int CNT_MAX = (N_SIZE > DRAIN_CYCLES) ? N_SIZE : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(N_SIZE);
    localparam logic [CNT_W-1:0] CNT_D = CNT_W'(DRAIN_CYCLES);
    localparam logic [ROW_W:0]   ROWS  = (ROW_W + 1)'(N_SIZE);

    feeder_state_e state;

    logic [N_SIZE-1:0] a_mask;
    logic [N_SIZE-1:0] b_mask;
    logic [N_SIZE-1:0] a_mask_nx;
    logic [N_SIZE-1:0] b_mask_nx;
    logic [N_SIZE-1:0] row_hot;
    logic [CNT_W-1:0]  cnt;
    logic [ROW_W-1:0]  rd_idx;
    logic [W-1:0]      a_col;
    logic [W-1:0]      b_row;
    logic              wr_fire;
    logic              row_ok;
    logic              a_wr;
    logic              b_wr;
    logic              full;

    assign wr_fire   = wr_valid & wr_ready;
    assign row_ok    = {1'b0, wr_row} < ROWS;
    assign row_hot   = N_SIZE'(1) << wr_row;
    assign a_wr      = wr_fire & row_ok & ~wr_sel;
    assign b_wr      = wr_fire & row_ok & wr_sel;
    assign a_mask_nx = a_mask | (a_wr ? row_hot : '0);
    assign b_mask_nx = b_mask | (b_wr ? row_hot : '0);
    assign full      = (&a_mask_nx) && (&b_mask_nx);
    assign rd_idx    = (cnt < CNT_N) ? cnt[ROW_W-1:0] : '0;

    systolic_operand_feeder_operand_row_store #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE),
        .ROW_W     (ROW_W),
        .COL_READ  (1'b1)
    ) u_store_a (
        .clk     (clk),
        .wr_en   (a_wr),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (a_col)
    );

    systolic_operand_feeder_operand_row_store #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE),
        .ROW_W     (ROW_W),
        .COL_READ  (1'b0)
    ) u_store_b (
        .clk     (clk),
        .wr_en   (b_wr),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (b_row)
    );

    // cnt holds the number of beats issued in STREAM, the drain cycle in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LOAD;
            a_mask       <= '0;
            b_mask       <= '0;
            cnt          <= '0;
            wr_ready     <= 1'b1;
            acc_clear    <= 1'b0;
            valid_out    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            matrix_a_out <= '0;
            matrix_b_out <= '0;
        end else begin
            acc_clear    <= 1'b0;
            valid_out    <= 1'b0;
            done         <= 1'b0;
            matrix_a_out <= '0;
            matrix_b_out <= '0;
            unique case (state)
                S_LOAD: begin
                    a_mask <= a_mask_nx;
                    b_mask <= b_mask_nx;
                    if (full) begin
                        state     <= S_CLEAR;
                        wr_ready  <= 1'b0;
                        busy      <= 1'b1;
                        acc_clear <= 1'b1;
                        cnt       <= '0;
                    end
                end
                S_CLEAR: begin
                    state        <= S_STREAM;
                    valid_out    <= 1'b1;
                    matrix_a_out <= a_col;
                    matrix_b_out <= b_row;
                    cnt          <= CNT_W'(1);
                end
                S_STREAM: begin
                    if (cnt < CNT_N) begin
                        valid_out    <= 1'b1;
                        matrix_a_out <= a_col;
                        matrix_b_out <= b_row;
                        cnt          <= cnt + CNT_W'(1);
                    end else if (DRAIN_CYCLES == 0) begin
                        state    <= S_LOAD;
                        a_mask   <= '0;
                        b_mask   <= '0;
                        cnt      <= '0;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state <= S_DRAIN;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNT_D) begin
                        state    <= S_LOAD;
                        a_mask   <= '0;
                        b_mask   <= '0;
                        cnt      <= '0;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef FEEDER_ERR_EN
    logic dup_row;

    assign dup_row = wr_sel ? |(b_mask & row_hot) : |(a_mask & row_hot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_row <= 1'b0;
        end else if (wr_fire && (!row_ok || dup_row)) begin
            err_row <= 1'b1;
        end
    end
`endif

endmodule
